// File: rtl/reciprocal_iter.sv
// Iterative Newton-Raphson fixed-point reciprocal behind req/ack handshakes.
// One (WIDTH+2)x(WIDTH+2) multiplier is time-shared between the two half-steps of each iteration.
module reciprocal_iter #(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned FRAC   = 10,
   parameter int unsigned ITERS  = 3,
   parameter int unsigned SIGNED = 1,
   parameter int unsigned TAG_W  = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] t_0_dat,
   input  logic [TAG_W-1:0] t_0_tag,
   input  logic             t_0_req,
   output logic             t_0_ack,
   output logic [WIDTH-1:0] i_0_dat,
   output logic [TAG_W-1:0] i_0_tag,
   output logic             i_0_dz,
   output logic             i_0_sat,
   output logic             i_0_req,
   input  logic             i_0_ack
);

   localparam int unsigned YW  = WIDTH + 2;
   localparam int unsigned PRW = 2 * YW;
   localparam int unsigned PW  = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam int unsigned IW  = 3;
   localparam int unsigned RW  = YW + 2 * FRAC;
   localparam int unsigned SW  = $clog2(RW) + 1;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_NORM   = 3'd1;
   localparam logic [2:0] S_MUL_A  = 3'd2;
   localparam logic [2:0] S_MUL_B  = 3'd3;
   localparam logic [2:0] S_DENORM = 3'd4;
   localparam logic [2:0] S_OUT    = 3'd5;

   localparam logic [RW-1:0]    LIM     = (SIGNED != 0) ? RW'({(WIDTH-1){1'b1}}) : RW'({WIDTH{1'b1}});
   localparam logic [WIDTH-1:0] LIM_W   = WIDTH'(LIM);
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [YW-1:0]    THREE   = {2'b11, {WIDTH{1'b0}}};
   localparam logic [YW-1:0]    TWO     = {2'b10, {WIDTH{1'b0}}};

   logic [2:0]       state_q, state_d;
   logic [IW-1:0]    iter_q, iter_d;
   logic [WIDTH-1:0] x_q, x_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic [WIDTH-1:0] z_q, z_d;
   logic [YW-1:0]    y_q, y_d;
   logic [YW-1:0]    t_q, t_d;
   logic [PW-1:0]    p_q, p_d;
   logic             dz_q, dz_d;
   logic             neg_q, neg_d;

   logic [WIDTH-1:0] dat_q, dat_d;
   logic [TAG_W-1:0] otag_q, otag_d;
   logic             odz_q, odz_d;
   logic             osat_q, osat_d;
   logic             oreq_q, oreq_d;

   logic             neg_c;
   logic [WIDTH-1:0] mag_c;
   logic [PW-1:0]    lead_c;
   logic [WIDTH-1:0] znorm_c;
   logic [YW-1:0]    u_c;
   logic [YW-1:0]    mul_a_c;
   logic [YW-1:0]    mul_b_c;
   logic [PRW-1:0]   prod_c;
   logic [YW-1:0]    mul_res_c;
   logic [SW-1:0]    sh_c;
   logic [RW-1:0]    r_c;
   logic             rsat_c;
   logic [WIDTH-1:0] rlim_c;
   logic [WIDTH-1:0] rdat_c;

   // Magnitude, leading-one position and normalised mantissa of the held operand
   always_comb begin
      neg_c  = (SIGNED != 0) && x_q[WIDTH-1];
      mag_c  = neg_c ? (~x_q + WIDTH'(1)) : x_q;
      lead_c = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         if (mag_c[i]) begin
            lead_c = PW'(i);
         end
      end
      if (mag_c == '0) begin
         znorm_c = MIN_NEG;
      end else begin
         znorm_c = mag_c << (PW'(WIDTH - 1) - lead_c);
      end
   end

   // Shared multiplier: z*y in MUL_A, y*(2-t) in MUL_B
   always_comb begin
      u_c = TWO - t_q;
      if (state_q == S_MUL_A) begin
         mul_a_c = YW'(z_q);
         mul_b_c = y_q;
      end else begin
         mul_a_c = y_q;
         mul_b_c = u_c;
      end
      prod_c    = PRW'(mul_a_c) * PRW'(mul_b_c);
      mul_res_c = YW'(prod_c >> WIDTH);
   end

   // Rescale y to the output format; the wide pre-shift keeps every bit before truncation
   always_comb begin
      sh_c   = SW'(p_q) + SW'(WIDTH + 1);
      r_c    = (RW'(y_q) << (2 * FRAC)) >> sh_c;
      rsat_c = !dz_q && (r_c > LIM);
      rlim_c = (dz_q || rsat_c) ? LIM_W : r_c[WIDTH-1:0];
      if (neg_q && rsat_c) begin
         rdat_c = MIN_NEG;
      end else if (neg_q) begin
         rdat_c = ~rlim_c + WIDTH'(1);
      end else begin
         rdat_c = rlim_c;
      end
   end

   // Next-state, datapath updates and handshake decode
   always_comb begin
      state_d = state_q;
      iter_d  = iter_q;
      x_d     = x_q;
      tag_d   = tag_q;
      z_d     = z_q;
      y_d     = y_q;
      t_d     = t_q;
      p_d     = p_q;
      dz_d    = dz_q;
      neg_d   = neg_q;
      dat_d   = dat_q;
      otag_d  = otag_q;
      odz_d   = odz_q;
      osat_d  = osat_q;
      oreq_d  = oreq_q;
      t_0_ack = 1'b0;

      case (state_q)
         S_IDLE: begin
            t_0_ack = 1'b1;
            if (t_0_req) begin
               x_d     = t_0_dat;
               tag_d   = t_0_tag;
               state_d = S_NORM;
            end
         end
         S_NORM: begin
            z_d     = znorm_c;
            y_d     = THREE - {1'b0, znorm_c, 1'b0};
            p_d     = lead_c;
            dz_d    = (mag_c == '0);
            neg_d   = neg_c;
            iter_d  = '0;
            state_d = S_MUL_A;
         end
         S_MUL_A: begin
            t_d     = mul_res_c;
            state_d = S_MUL_B;
         end
         S_MUL_B: begin
            y_d = mul_res_c;
            if (iter_q < IW'(ITERS - 1)) begin
               iter_d  = iter_q + IW'(1);
               state_d = S_MUL_A;
            end else begin
               state_d = S_DENORM;
            end
         end
         S_DENORM: begin
            dat_d   = rdat_c;
            otag_d  = tag_q;
            odz_d   = dz_q;
            osat_d  = rsat_c;
            oreq_d  = 1'b1;
            state_d = S_OUT;
         end
         S_OUT: begin
            // Consuming the result frees the slot in the same cycle, so a waiting operand goes straight in
            if (i_0_ack) begin
               t_0_ack = 1'b1;
               oreq_d  = 1'b0;
               if (t_0_req) begin
                  x_d     = t_0_dat;
                  tag_d   = t_0_tag;
                  state_d = S_NORM;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         iter_q  <= '0;
         x_q     <= '0;
         tag_q   <= '0;
         z_q     <= '0;
         y_q     <= '0;
         t_q     <= '0;
         p_q     <= '0;
         dz_q    <= 1'b0;
         neg_q   <= 1'b0;
         dat_q   <= '0;
         otag_q  <= '0;
         odz_q   <= 1'b0;
         osat_q  <= 1'b0;
         oreq_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         iter_q  <= iter_d;
         x_q     <= x_d;
         tag_q   <= tag_d;
         z_q     <= z_d;
         y_q     <= y_d;
         t_q     <= t_d;
         p_q     <= p_d;
         dz_q    <= dz_d;
         neg_q   <= neg_d;
         dat_q   <= dat_d;
         otag_q  <= otag_d;
         odz_q   <= odz_d;
         osat_q  <= osat_d;
         oreq_q  <= oreq_d;
      end
   end

   assign i_0_dat = dat_q;
   assign i_0_tag = otag_q;
   assign i_0_dz  = odz_q;
   assign i_0_sat = osat_q;
   assign i_0_req = oreq_q;

endmodule
